// File: rtl/instr_fetch_ctrl_if.sv
// Signal bundle between instr_fetch_ctrl and its environment: program load
// stream, instruction memory ports and fetched-instruction outputs.
interface instr_fetch_ctrl_if #(
  parameter int unsigned N_WORDS = 32,
  parameter int unsigned WIDTH   = 32
);
  localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  logic             load_start;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_last;
  logic             load_ready;
  logic             imem_we;
  logic [IDX_W-1:0] imem_waddr;
  logic [WIDTH-1:0] imem_wdata;
  logic [IDX_W-1:0] imem_raddr;
  logic [WIDTH-1:0] imem_rdata;
  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic             fault;

  modport master (
    output load_start, load_valid, load_data, load_last, imem_rdata,
           stall, redirect, redirect_pc,
    input  load_ready, imem_we, imem_waddr, imem_wdata, imem_raddr,
           pc, instr, instr_valid, fault
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, imem_rdata,
           stall, redirect, redirect_pc,
    output load_ready, imem_we, imem_waddr, imem_wdata, imem_raddr,
           pc, instr, instr_valid, fault
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: loads a program into instruction memory,
// then fetches sequentially with stall/redirect and sticky range faults.
module instr_fetch_ctrl #(
  parameter int unsigned      N_WORDS = 32,
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] BASE    = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_ctrl_if.slave bus
);
  localparam int unsigned      IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [WIDTH-1:0] SPAN     = WIDTH'(4 * N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] wptr_q, wptr_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] offset_s;
  logic             legal_s;
  logic             accept_s;

  // The offset comparison alone also rejects addresses below BASE via wrap,
  // but the explicit lower bound keeps the intent readable.
  assign offset_s = fetch_pc_q - BASE;
  assign legal_s  = (fetch_pc_q >= BASE) && (offset_s < SPAN) && (fetch_pc_q[1:0] == 2'b00);
  assign accept_s = (state_q == LOAD) && bus.load_valid;

  assign bus.load_ready  = (state_q == LOAD);
  assign bus.imem_we     = accept_s;
  assign bus.imem_waddr  = wptr_q;
  assign bus.imem_wdata  = bus.load_data;
  assign bus.imem_raddr  = IDX_W'(offset_s >> 2);
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fault       = fault_q;

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wptr_q        <= {IDX_W{1'b0}};
      fetch_pc_q    <= BASE;
      pc_q          <= {WIDTH{1'b0}};
      instr_q       <= {WIDTH{1'b0}};
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state logic; in RUN the priority is load_start > redirect > stall > fetch.
  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          wptr_d  = {IDX_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          wptr_d = wptr_q + IDX_W'(1);
          if (bus.load_last || (wptr_q == LAST_IDX)) begin
            state_d    = RUN;
            fetch_pc_d = BASE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      RUN: begin
        if (bus.load_start) begin
          state_d       = LOAD;
          wptr_d        = {IDX_W{1'b0}};
          instr_valid_d = 1'b0;
        end else if (bus.redirect) begin
          fetch_pc_d    = bus.redirect_pc;
          instr_valid_d = 1'b0;
        end else if (bus.stall) begin
          state_d = RUN;
        end else if (legal_s) begin
          instr_d       = bus.imem_rdata;
          pc_d          = fetch_pc_q;
          instr_valid_d = 1'b1;
          fetch_pc_d    = fetch_pc_q + WIDTH'(4);
        end else begin
          state_d       = FAULT;
          instr_valid_d = 1'b0;
          fault_d       = 1'b1;
          pc_d          = fetch_pc_q;
        end
      end
      FAULT: begin
        if (bus.load_start) begin
          state_d = LOAD;
          wptr_d  = {IDX_W{1'b0}};
          fault_d = 1'b0;
        end else begin
          state_d = FAULT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus randomized traffic,
// checked against a transaction-level model of load and fetch behaviour.
module tb_instr_fetch_ctrl;
  localparam int unsigned N    = 32;
  localparam int unsigned W    = 32;
  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_FAULT = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;

  logic [31:0] tb_mem [0:N-1];
  logic [31:0] m_mem  [0:N-1];
  int          m_mode;
  int          m_wptr;
  logic [31:0] m_fetch, m_pc, m_instr;
  logic        m_valid, m_fault;

  instr_fetch_ctrl_if #(.N_WORDS(N), .WIDTH(W)) bus ();
  instr_fetch_ctrl #(.N_WORDS(N), .WIDTH(W), .BASE(BASE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: synchronous write, combinational read.
  always @(posedge clk) if (bus.imem_we) tb_mem[bus.imem_waddr] <= bus.imem_wdata;
  assign bus.imem_rdata = tb_mem[bus.imem_raddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    longint unsigned lo, hi, x;
    lo = longint'(BASE);
    hi = lo + longint'(4 * N);
    x  = longint'(a);
    return (x >= lo) && (x < hi) && (x % 4 == 0);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_wptr = 0; m_fetch = BASE;
    m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (m_mode == M_IDLE) begin
      if (bus.load_start) begin m_mode = M_LOAD; m_wptr = 0; end
    end else if (m_mode == M_LOAD) begin
      if (bus.load_valid) begin
        m_mem[m_wptr] = bus.load_data;
        if (bus.load_last || m_wptr == N - 1) begin m_mode = M_RUN; m_fetch = BASE; end
        m_wptr = (m_wptr + 1) % N;
      end
    end else if (m_mode == M_RUN) begin
      if (bus.load_start) begin
        m_mode = M_LOAD; m_wptr = 0; m_valid = 1'b0;
      end else if (bus.redirect) begin
        m_fetch = bus.redirect_pc; m_valid = 1'b0;
      end else if (!bus.stall) begin
        if (addr_ok(m_fetch)) begin
          m_pc = m_fetch; m_instr = m_mem[(m_fetch - BASE) / 4]; m_valid = 1'b1;
          m_fetch = m_fetch + 32'd4;
        end else begin
          m_mode = M_FAULT; m_valid = 1'b0; m_fault = 1'b1; m_pc = m_fetch;
        end
      end
    end else begin
      if (bus.load_start) begin m_mode = M_LOAD; m_wptr = 0; m_fault = 1'b0; end
    end
  endtask

  // One clock: check combinational load-port outputs, step model, check registers.
  task automatic cycle();
    logic we_exp;
    #1;
    we_exp = (m_mode == M_LOAD) && bus.load_valid && rst_n;
    chk("load_ready", 32'(bus.load_ready), 32'(m_mode == M_LOAD && rst_n));
    chk("imem_we", 32'(bus.imem_we), 32'(we_exp));
    if (we_exp) begin
      chk("imem_waddr", 32'(bus.imem_waddr), 32'(m_wptr));
      chk("imem_wdata", bus.imem_wdata, bus.load_data);
    end
    model_step();
    @(posedge clk);
    #1;
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    chk("fault", 32'(bus.fault), 32'(m_fault));
    chk("pc", bus.pc, m_pc);
    if (m_valid) chk("instr", bus.instr, m_instr);
  endtask

  task automatic quiet();
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = 32'h0;
    bus.load_last = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    quiet();
    model_reset();
    #2;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    chk("rst_ready", 32'(bus.load_ready), 32'h0);
    cycle(); cycle();
    rst_n = 1'b1;
    bus.load_valid = 1'b1;  // ignored while idle
    cycle();

    // Four-word load, last on the fourth beat.
    bus.load_start = 1'b1; bus.load_valid = 1'b0;
    cycle();
    bus.load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1; bus.load_data = 32'(17 * (i + 1)); bus.load_last = (i == 3);
      #1;
      chk("load4_we", 32'(bus.imem_we), 32'h1);
      chk("load4_waddr", 32'(bus.imem_waddr), 32'(i));
      cycle();
    end
    quiet();
    chk("load4_done_ready", 32'(bus.load_ready), 32'h0);
    cycle();
    chk("seq_pc0", bus.pc, 32'h0040_0000);
    chk("seq_instr0", bus.instr, 32'h0000_0011);
    cycle();
    chk("seq_pc1", bus.pc, 32'h0040_0004);
    chk("seq_instr1", bus.instr, 32'h0000_0022);

    // Three-cycle stall holds outputs, then resumes without skipping.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", bus.pc, 32'h0040_0004);
      chk("stall_valid", 32'(bus.instr_valid), 32'h1);
    end
    bus.stall = 1'b0;
    cycle();
    chk("resume_pc", bus.pc, 32'h0040_0008);
    chk("resume_instr", bus.instr, 32'h0000_0033);

    // Redirect wins over a simultaneous stall and costs one bubble.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0040_000C; bus.stall = 1'b1;
    cycle();
    chk("redir_bubble", 32'(bus.instr_valid), 32'h0);
    quiet();
    cycle();
    chk("redir_pc", bus.pc, 32'h0040_000C);
    chk("redir_instr", bus.instr, 32'h0000_0044);

    // Full-depth load with gaps; ends on the last word without load_last.
    bus.load_start = 1'b1;
    cycle();
    for (int k = 0; k < 300 && bus.load_ready; k++) begin
      bus.load_start = 1'($urandom_range(0, 1));
      bus.load_valid = 1'($urandom_range(0, 1));
      bus.load_data  = $urandom;
      cycle();
    end
    chk("full_load_done", 32'(bus.load_ready), 32'h0);
    quiet();

    // Randomized run traffic with redirects kept inside the loaded range.
    for (int k = 0; k < 80; k++) begin
      bus.stall       = ($urandom_range(0, 2) == 0);
      bus.redirect    = ($urandom_range(0, 4) == 0) || (m_fetch >= 32'h0040_0060);
      bus.redirect_pc = BASE + 32'(4 * $urandom_range(0, 23));
      bus.load_valid  = 1'($urandom_range(0, 1));
      bus.load_data   = $urandom;
      bus.load_last   = 1'($urandom_range(0, 1));
      cycle();
    end
    quiet();

    // Sequential fetch runs off the end of memory.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0040_0070;
    cycle();
    quiet();
    for (int k = 0; k < 16 && !bus.fault; k++) cycle();
    chk("end_fault", 32'(bus.fault), 32'h1);
    chk("end_fault_pc", bus.pc, 32'h0040_0080);
    for (int k = 0; k < 3; k++) begin
      bus.stall = 1'($urandom_range(0, 1)); bus.redirect = 1'b1; bus.redirect_pc = BASE;
      cycle();
      chk("fault_sticky", 32'(bus.fault), 32'h1);
    end
    quiet();

    // Recover with a one-word load.
    bus.load_start = 1'b1;
    cycle();
    chk("recover_fault_clr", 32'(bus.fault), 32'h0);
    bus.load_start = 1'b0; bus.load_valid = 1'b1; bus.load_last = 1'b1; bus.load_data = 32'hABCD_0001;
    cycle();
    quiet();
    cycle();
    chk("recover_pc", bus.pc, BASE);
    chk("recover_instr", bus.instr, 32'hABCD_0001);

    // Misaligned redirect target faults.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0040_0002;
    cycle();
    quiet();
    cycle();
    chk("misalign_fault", 32'(bus.fault), 32'h1);
    chk("misalign_pc", bus.pc, 32'h0040_0002);

    // Asynchronous reset in the middle of a load.
    bus.load_start = 1'b1;
    cycle();
    bus.load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1'b1; bus.load_data = 32'hC0DE_0000 + 32'(i);
      cycle();
    end
    bus.load_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_ready", 32'(bus.load_ready), 32'h0);
    chk("arst_we", 32'(bus.imem_we), 32'h0);
    chk("arst_pc", bus.pc, 32'h0);
    chk("arst_instr", bus.instr, 32'h0);
    chk("arst_valid", 32'(bus.instr_valid), 32'h0);
    chk("arst_fault", 32'(bus.fault), 32'h0);
    cycle(); cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.stall = 1'($urandom_range(0, 1));
      cycle();
      chk("post_rst_idle", 32'(bus.instr_valid), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
